risk_mem_ctrl: RTL



---
 rtl/risk_pkg.sv | 24 ++
 rtl/risk_mem_ctrl_if.sv | 41 ++++
 rtl/risk_rsp_track.sv | 32 +++
 rtl/risk_mem_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/risk_pkg.sv
// rtl/risk_pkg.sv - shared sizes, FSM states and tracker entry for the risk_mem controller
package risk_pkg;
    localparam int SZ     = 4;
    localparam int LOGCNT = 5;
    localparam int BITS   = 18;
    localparam int AW     = 10 + LOGCNT;
    localparam int CW     = 8;
    localparam int TILE_W = BITS * SZ * SZ;
    localparam int RD_LAT = 4;
    localparam int WE_DLY = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD       = 2'd1,
        ST_WR_ISSUE = 2'd2,
        ST_WR_GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic id;
        logic last;
    } trk_entry_t;
endpackage

// File: rtl/risk_mem_ctrl_if.sv
// rtl/risk_mem_ctrl_if.sv - requester, write-data, memory and response signals of risk_mem_ctrl
interface risk_mem_ctrl_if;
    import risk_pkg::*;

    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_we;
    logic [1:0][AW-1:0]     req_addr;
    logic [1:0][AW-2:0]     req_stride_x;
    logic [1:0][AW-2:0]     req_stride_y;
    logic [1:0][AW-1:0]     req_step;
    logic [1:0][CW-1:0]     req_count;
    logic [1:0]             wd_valid;
    logic [1:0]             wd_ready;
    logic [1:0][TILE_W-1:0] wd_data;
    logic [AW-1:0]          mem_addr;
    logic [AW-2:0]          mem_stride_x;
    logic [AW-2:0]          mem_stride_y;
    logic [TILE_W-1:0]      mem_dat_w;
    logic                   mem_we;
    logic [TILE_W-1:0]      mem_dat_r;
    logic                   rsp_valid;
    logic                   rsp_id;
    logic                   rsp_last;
    logic [TILE_W-1:0]      rsp_data;
    logic                   busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_stride_x, req_stride_y, req_step, req_count,
        input  wd_valid, wd_data, mem_dat_r,
        output req_ready, wd_ready, mem_addr, mem_stride_x, mem_stride_y, mem_dat_w, mem_we,
        output rsp_valid, rsp_id, rsp_last, rsp_data, busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_stride_x, req_stride_y, req_step, req_count,
        output wd_valid, wd_data, mem_dat_r,
        input  req_ready, wd_ready, mem_addr, mem_stride_x, mem_stride_y, mem_dat_w, mem_we,
        input  rsp_valid, rsp_id, rsp_last, rsp_data, busy
    );
endinterface

// File: rtl/risk_rsp_track.sv
// rtl/risk_rsp_track.sv - fixed-latency read tracker; tail lines up with returning memory data
module risk_rsp_track
    import risk_pkg::*;
#(
    parameter int DEPTH = RD_LAT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  trk_entry_t push,
    output trk_entry_t tail,
    output logic       empty
);
    trk_entry_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= push;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage[i].valid) empty = 1'b0;
        end
    end

    assign tail = stage[DEPTH-1];
endmodule

// File: rtl/risk_mem_ctrl.sv
// rtl/risk_mem_ctrl.sv - two-requester round-robin tile burst sequencer in front of risk_mem
module risk_mem_ctrl
    import risk_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    risk_mem_ctrl_if.slave bus
);
    localparam int GW = (WE_DLY > 1) ? $clog2(WE_DLY) : 1;

    state_t            state;
    logic [AW-1:0]     cur;
    logic [AW-1:0]     step;
    logic [AW-2:0]     stride_x;
    logic [AW-2:0]     stride_y;
    logic [CW-1:0]     remaining;
    logic              id;
    logic              rr;
    logic [GW-1:0]     gap_cnt;
    logic [AW-1:0]     mem_addr_q;
    logic [AW-2:0]     mem_stride_x_q;
    logic [AW-2:0]     mem_stride_y_q;
    logic [TILE_W-1:0] mem_dat_w_q;
    logic              mem_we_q;
    trk_entry_t        iss;
    trk_entry_t        tail;
    logic              trk_empty;
    logic              rd_idle;
    logic [1:0]        elig;
    logic              grant;
    logic              winner;
    logic              wr_take;

    // iss is the entry issued this cycle; it feeds the tracker so the tail lands at issue + RD_LAT
    assign rd_idle = trk_empty & ~iss.valid;

    // Writes are only eligible once no read is outstanding, so mem_we never collides with read data
    always_comb begin
        elig   = '0;
        grant  = 1'b0;
        winner = rr;
        if (resetn && state == ST_IDLE) begin
            for (int i = 0; i < 2; i++) begin
                elig[i] = bus.req_valid[i] & (~bus.req_we[i] | rd_idle);
            end
            if (elig[rr]) begin
                grant  = 1'b1;
                winner = rr;
            end else if (elig[~rr]) begin
                grant  = 1'b1;
                winner = ~rr;
            end
        end
    end

    assign wr_take       = (state == ST_WR_ISSUE) && bus.wd_valid[id];
    assign bus.req_ready = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.wd_ready  = wr_take ? (id ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            cur            <= '0;
            step           <= '0;
            stride_x       <= '0;
            stride_y       <= '0;
            remaining      <= '0;
            id             <= 1'b0;
            rr             <= 1'b0;
            gap_cnt        <= '0;
            mem_addr_q     <= '0;
            mem_stride_x_q <= '0;
            mem_stride_y_q <= '0;
            mem_dat_w_q    <= '0;
            mem_we_q       <= 1'b0;
            iss            <= '0;
        end else begin
            iss      <= '0;
            mem_we_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        cur       <= bus.req_addr[winner];
                        step      <= bus.req_step[winner];
                        stride_x  <= bus.req_stride_x[winner];
                        stride_y  <= bus.req_stride_y[winner];
                        remaining <= bus.req_count[winner];
                        id        <= winner;
                        rr        <= ~winner;
                        state     <= bus.req_we[winner] ? ST_WR_ISSUE : ST_RD;
                    end
                end
                ST_RD: begin
                    mem_addr_q     <= cur;
                    mem_stride_x_q <= stride_x;
                    mem_stride_y_q <= stride_y;
                    iss.valid      <= 1'b1;
                    iss.id         <= id;
                    iss.last       <= (remaining == '0);
                    cur            <= cur + step;
                    if (remaining == '0) state <= ST_IDLE;
                    else                 remaining <= remaining - CW'(1);
                end
                ST_WR_ISSUE: begin
                    if (wr_take) begin
                        mem_addr_q     <= cur;
                        mem_stride_x_q <= stride_x;
                        mem_stride_y_q <= stride_y;
                        mem_dat_w_q    <= bus.wd_data[id];
                        gap_cnt        <= '0;
                        state          <= ST_WR_GAP;
                    end
                end
                ST_WR_GAP: begin
                    // mem_we is registered here so it shows up WE_DLY cycles after the address
                    if (gap_cnt == GW'(WE_DLY - 1)) begin
                        mem_we_q <= 1'b1;
                        cur      <= cur + step;
                        if (remaining == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            remaining <= remaining - CW'(1);
                            state     <= ST_WR_ISSUE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    risk_rsp_track #(.DEPTH(RD_LAT)) u_track (
        .clk   (clk),
        .rst_n (resetn),
        .push  (iss),
        .tail  (tail),
        .empty (trk_empty)
    );

    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_stride_x = mem_stride_x_q;
    assign bus.mem_stride_y = mem_stride_y_q;
    assign bus.mem_dat_w    = mem_dat_w_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.rsp_valid    = tail.valid;
    assign bus.rsp_id       = tail.id;
    assign bus.rsp_last     = tail.last;
    assign bus.rsp_data     = bus.mem_dat_r;
    assign bus.busy         = (state != ST_IDLE) | ~rd_idle;
endmodule
